// File: rtl/ttt_pkg.sv
// Shared cell encoding and win-line tables for the tic-tac-toe board.
package ttt_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_X     = 2'b01,
    CELL_O     = 2'b10
  } cell_t;

  localparam int unsigned BOARD_CELLS = 9;
  localparam int unsigned NUM_LINES   = 8;

  localparam int unsigned WIN_LINES [NUM_LINES][3] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
    '{0, 4, 8}, '{2, 4, 6}
  };

  // Positions 9..15 read as empty; range is checked separately by the caller.
  function automatic logic [1:0] cell_at(input logic [17:0] board, input logic [3:0] pos);
    cell_at = CELL_EMPTY;
    for (int unsigned i = 0; i < BOARD_CELLS; i++) begin
      if (pos == 4'(i)) cell_at = board[2*i +: 2];
    end
  endfunction

endpackage

// File: rtl/ttt_board_if.sv
// Game FSM <-> board responder signal bundle.
interface ttt_board_if;
  import ttt_pkg::*;

  logic        new_game;
  logic        o_play;
  logic        x_play;
  logic [3:0]  pos_o;
  logic [3:0]  pos_x;
  logic [17:0] cells;
  logic        illegal_move;
  logic        illegal_x;
  logic        win;
  logic [1:0]  winner;
  logic        no_space;
  logic [3:0]  move_count;

  modport master (
    output new_game, o_play, x_play, pos_o, pos_x,
    input  cells, illegal_move, illegal_x, win, winner, no_space, move_count
  );

  modport slave (
    input  new_game, o_play, x_play, pos_o, pos_x,
    output cells, illegal_move, illegal_x, win, winner, no_space, move_count
  );
endinterface

// File: rtl/ttt_line_check.sv
// Combinational detector for a completed row, column or diagonal.
module ttt_line_check
  import ttt_pkg::*;
(
  input  logic [17:0] board,
  output logic        win,
  output logic [1:0]  winner
);

  logic [1:0] a, b, c;

  always_comb begin
    win    = 1'b0;
    winner = CELL_EMPTY;
    a      = CELL_EMPTY;
    b      = CELL_EMPTY;
    c      = CELL_EMPTY;
    for (int unsigned l = 0; l < NUM_LINES; l++) begin
      a = board[2*WIN_LINES[l][0] +: 2];
      b = board[2*WIN_LINES[l][1] +: 2];
      c = board[2*WIN_LINES[l][2] +: 2];
      if (a != CELL_EMPTY && a == b && b == c) begin
        win    = 1'b1;
        winner = a;
      end
    end
  end

endmodule

// File: rtl/ttt_board.sv
// Board-state responder: stores nine cells, applies O/X moves, reports status.
module ttt_board
  import ttt_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  ttt_board_if.slave    bus
);

  logic [17:0] cells_q, cells_n;
  logic [3:0]  cnt_q, cnt_n;
  logic        win_q, no_space_q;
  logic [1:0]  winner_q;
  logic        legal_o, legal_x;
  logic        wr;
  logic [3:0]  wr_pos;
  logic [1:0]  wr_val;
  logic        lc_win;
  logic [1:0]  lc_winner;

  assign legal_o = (bus.pos_o <= 4'd8) && (cell_at(cells_q, bus.pos_o) == CELL_EMPTY) && !win_q;
  assign legal_x = (bus.pos_x <= 4'd8) && (cell_at(cells_q, bus.pos_x) == CELL_EMPTY) && !win_q;

  // An asserted o_play masks x_play even when the O move itself is rejected.
  always_comb begin
    wr      = 1'b0;
    wr_pos  = '0;
    wr_val  = CELL_EMPTY;
    cells_n = cells_q;
    cnt_n   = cnt_q;
    if (bus.o_play) begin
      if (legal_o) begin
        wr     = 1'b1;
        wr_pos = bus.pos_o;
        wr_val = CELL_O;
      end
    end else if (bus.x_play && legal_x) begin
      wr     = 1'b1;
      wr_pos = bus.pos_x;
      wr_val = CELL_X;
    end
    if (wr) begin
      for (int unsigned i = 0; i < BOARD_CELLS; i++) begin
        if (wr_pos == 4'(i)) cells_n[2*i +: 2] = wr_val;
      end
      cnt_n = (cnt_q == 4'd9) ? 4'd9 : cnt_q + 4'd1;
    end
  end

  ttt_line_check u_line_check (
    .board  (cells_n),
    .win    (lc_win),
    .winner (lc_winner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cells_q    <= '0;
      cnt_q      <= '0;
      win_q      <= 1'b0;
      winner_q   <= CELL_EMPTY;
      no_space_q <= 1'b0;
    end else if (bus.new_game) begin
      cells_q    <= '0;
      cnt_q      <= '0;
      win_q      <= 1'b0;
      winner_q   <= CELL_EMPTY;
      no_space_q <= 1'b0;
    end else if (wr) begin
      cells_q    <= cells_n;
      cnt_q      <= cnt_n;
      win_q      <= lc_win;
      winner_q   <= lc_winner;
      no_space_q <= (cnt_n == 4'd9);
    end
  end

  assign bus.cells        = cells_q;
  assign bus.move_count   = cnt_q;
  assign bus.win          = win_q;
  assign bus.winner       = winner_q;
  assign bus.no_space     = no_space_q;
  assign bus.illegal_move = !legal_o;
  assign bus.illegal_x    = !legal_x;

endmodule

// File: tb/tb_ttt_board.sv
// Directed table-driven bench for ttt_board plus multi-cycle corner sequences.
module tb_ttt_board;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ttt_board_if bus();

  ttt_board u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    ng, op, xp, po, px;
    int    ill_o, ill_x;
    string brd;
    int    cnt, w, wn, ns;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [17:0] board_of(input string s);
    logic [17:0] b;
    b = '0;
    for (int i = 0; i < 9; i++) begin
      if (s[i] == "X")      b[2*i +: 2] = 2'b01;
      else if (s[i] == "O") b[2*i +: 2] = 2'b10;
    end
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input int ng, op, xp, po, px, ill_o, ill_x,
                     input string brd, input int cnt, w, wn, ns);
    vec_t v;
    v.ng = ng; v.op = op; v.xp = xp; v.po = po; v.px = px;
    v.ill_o = ill_o; v.ill_x = ill_x; v.brd = brd;
    v.cnt = cnt; v.w = w; v.wn = wn; v.ns = ns;
    vecs.push_back(v);
  endtask

  task automatic check_post(input string tag, input string brd, input int cnt, w, wn, ns);
    check({tag, ".cells"},      32'(bus.cells),      32'(board_of(brd)));
    check({tag, ".move_count"}, 32'(bus.move_count), 32'(cnt));
    check({tag, ".win"},        32'(bus.win),        32'(w));
    check({tag, ".winner"},     32'(bus.winner),     32'(wn));
    check({tag, ".no_space"},   32'(bus.no_space),   32'(ns));
  endtask

  initial begin
    //  ng op xp po px ilo ilx  board        cnt w wn ns
    // O at 4, then occupied / out-of-range rejects
    add(0, 1, 0, 4, 0, 0, 0, "....O....", 1, 0, 0, 0);
    add(0, 0, 1, 0, 4, 0, 1, "....O....", 1, 0, 0, 0);
    add(0, 1, 0, 12, 0, 1, 0, "....O....", 1, 0, 0, 0);
    add(1, 0, 0, 4, 0, 1, 0, ".........", 0, 0, 0, 0);
    // O wins the 0-4-8 diagonal; later writes rejected
    add(0, 1, 0, 0, 1, 0, 0, "O........", 1, 0, 0, 0);
    add(0, 0, 1, 0, 1, 1, 0, "OX.......", 2, 0, 0, 0);
    add(0, 1, 0, 4, 1, 0, 1, "OX..O....", 3, 0, 0, 0);
    add(0, 0, 1, 4, 2, 1, 0, "OXX.O....", 4, 0, 0, 0);
    add(0, 1, 0, 8, 3, 0, 0, "OXX.O...O", 5, 1, 2, 0);
    add(0, 0, 1, 8, 3, 1, 1, "OXX.O...O", 5, 1, 2, 0);
    add(0, 1, 0, 5, 9, 1, 1, "OXX.O...O", 5, 1, 2, 0);
    add(1, 0, 0, 0, 0, 1, 1, ".........", 0, 0, 0, 0);
    // Full-board draw
    add(0, 1, 0, 0, 9, 0, 1, "O........", 1, 0, 0, 0);
    add(0, 0, 1, 9, 1, 1, 0, "OX.......", 2, 0, 0, 0);
    add(0, 1, 0, 2, 9, 0, 1, "OXO......", 3, 0, 0, 0);
    add(0, 0, 1, 9, 4, 1, 0, "OXO.X....", 4, 0, 0, 0);
    add(0, 1, 0, 3, 9, 0, 1, "OXOOX....", 5, 0, 0, 0);
    add(0, 0, 1, 9, 5, 1, 0, "OXOOXX...", 6, 0, 0, 0);
    add(0, 1, 0, 7, 9, 0, 1, "OXOOXX.O.", 7, 0, 0, 0);
    add(0, 0, 1, 9, 6, 1, 0, "OXOOXXXO.", 8, 0, 0, 0);
    add(0, 1, 0, 8, 9, 0, 1, "OXOOXXXOO", 9, 0, 0, 1);
    add(0, 1, 0, 4, 0, 1, 1, "OXOOXXXOO", 9, 0, 0, 1);
    add(1, 0, 0, 0, 0, 1, 1, ".........", 0, 0, 0, 0);
    // Simultaneous strobes: X is dropped even when O is illegal
    add(0, 1, 1, 0, 1, 0, 0, "O........", 1, 0, 0, 0);
    add(1, 1, 1, 2, 3, 0, 0, ".........", 0, 0, 0, 0);
    add(0, 1, 1, 9, 1, 1, 0, ".........", 0, 0, 0, 0);
    // X wins the middle row
    add(0, 0, 1, 9, 3, 1, 0, "...X.....", 1, 0, 0, 0);
    add(0, 1, 0, 0, 9, 0, 1, "O..X.....", 2, 0, 0, 0);
    add(0, 0, 1, 9, 4, 1, 0, "O..XX....", 3, 0, 0, 0);
    add(0, 1, 0, 1, 9, 0, 1, "OO.XX....", 4, 0, 0, 0);
    add(0, 0, 1, 9, 5, 1, 0, "OO.XXX...", 5, 1, 1, 0);

    bus.new_game = 1'b0; bus.o_play = 1'b0; bus.x_play = 1'b0;
    bus.pos_o = 4'd0; bus.pos_x = 4'd9;
    repeat (2) @(posedge clk);
    #1;
    check_post("reset", ".........", 0, 0, 0, 0);
    check("reset.illegal_move_p0", 32'(bus.illegal_move), 32'd0);
    check("reset.illegal_x_p9",    32'(bus.illegal_x),    32'd1);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      bus.new_game = vecs[i].ng[0];
      bus.o_play   = vecs[i].op[0];
      bus.x_play   = vecs[i].xp[0];
      bus.pos_o    = 4'(vecs[i].po);
      bus.pos_x    = 4'(vecs[i].px);
      #1;
      check($sformatf("v%0d.illegal_move", i), 32'(bus.illegal_move), 32'(vecs[i].ill_o));
      check($sformatf("v%0d.illegal_x", i),    32'(bus.illegal_x),    32'(vecs[i].ill_x));
      @(posedge clk);
      #1;
      check_post($sformatf("v%0d", i), vecs[i].brd, vecs[i].cnt, vecs[i].w, vecs[i].wn, vecs[i].ns);
    end

    // Asynchronous reset between edges with five moves on the board
    @(negedge clk);
    bus.new_game = 1'b0; bus.o_play = 1'b0; bus.x_play = 1'b0;
    bus.pos_o = 4'd4; bus.pos_x = 4'd0;
    #2 rst = 1'b1;
    #1;
    check_post("async_rst", ".........", 0, 0, 0, 0);
    check("async_rst.illegal_move", 32'(bus.illegal_move), 32'd0);
    check("async_rst.illegal_x",    32'(bus.illegal_x),    32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Strobe held for three cycles writes once
    @(negedge clk);
    bus.o_play = 1'b1; bus.pos_o = 4'd4;
    repeat (3) @(posedge clk);
    #1;
    check_post("held_strobe", "....O....", 1, 0, 0, 0);
    check("held_strobe.illegal_move", 32'(bus.illegal_move), 32'd1);
    @(negedge clk);
    bus.o_play = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
